instruction_encoder_rv32i: RTL and testbench

Assembles RV32I instruction words from decoded fields. It is the inverse of the team's instruction splitter: format select, opcode, rd, f3, r1, r2, f7 and an immediate go in; a correctly bit-scattered 32-bit word comes out. Accepted words are buffered in a small FIFO and tagged with a sequential byte address. The block feeds the program loader / instruction-memory write port and is used by self-checking benches.

---
 rtl/instruction_encoder_rv32i.sv | 185 ++++++++++++++++++
 tb/tb_instruction_encoder_rv32i.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_encoder_rv32i.sv
// instruction_encoder_rv32i
// Assembles RV32I instruction words from decoded fields, queues them in a
// small circular FIFO and tags each word with a sequential byte address.
//
// Optional feature macro: IMM_RANGE_CHECK_EN
//   defined   -> immediates are range-checked at acceptance; violators are
//                consumed, dropped, and pulse err_range
//   undefined -> immediates are truncated to the format, err_range is 0
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   start, base_addr        flush FIFO and load the address counter
//   in_valid/in_ready       field bundle handshake
//   in_fmt .. in_imm        decoded fields (fmt 0=R 1=I 2=S 3=B 4=U 5=J)
//   out_valid/out_ready     FIFO head handshake
//   out_instr, out_addr     head word and its tagged byte address
//   count                   FIFO occupancy
//   err_fmt, err_range      one-cycle error pulses for dropped bundles
module instruction_encoder_rv32i #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [ADDR_W-1:0]        base_addr,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [2:0]               in_fmt,
    input  logic [6:0]               in_opcode,
    input  logic [4:0]               in_rd,
    input  logic [2:0]               in_f3,
    input  logic [4:0]               in_r1,
    input  logic [4:0]               in_r2,
    input  logic [6:0]               in_f7,
    input  logic [31:0]              in_imm,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_instr,
    output logic [ADDR_W-1:0]        out_addr,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     err_fmt,
    output logic                     err_range
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned PTR_W = IDX_W + 1;

    localparam logic [2:0] FMT_R = 3'd0;
    localparam logic [2:0] FMT_I = 3'd1;
    localparam logic [2:0] FMT_S = 3'd2;
    localparam logic [2:0] FMT_B = 3'd3;
    localparam logic [2:0] FMT_U = 3'd4;
    localparam logic [2:0] FMT_J = 3'd5;

    typedef struct packed {
        logic [31:0]       instr;
        logic [ADDR_W-1:0] addr;
    } entry_t;

    entry_t             mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [ADDR_W-1:0]  next_addr;
    logic               rdy_q;

    logic               full_c;
    logic               empty_c;
    logic               fmt_ok_c;
    logic               range_ok_c;
    logic               accept_c;
    logic               push_c;
    logic               pop_c;
    logic [31:0]        word_c;

    // Pointer-derived FIFO status; the extra MSB separates full from empty.
    assign empty_c = (wr_ptr == rd_ptr);
    assign full_c  = (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]) &&
                     (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]);

    // rdy_q keeps in_ready low until the first edge after reset release.
    assign in_ready = rdy_q & ~full_c & ~start;
    assign accept_c = in_valid & in_ready;
    assign push_c   = accept_c & fmt_ok_c & range_ok_c;
    assign pop_c    = ~empty_c & out_ready & ~start;

    // Bit-scatter the fields into the selected instruction format.
    always_comb begin
        word_c   = '0;
        fmt_ok_c = 1'b1;
        case (in_fmt)
            FMT_R: word_c = {in_f7, in_r2, in_r1, in_f3, in_rd, in_opcode};
            FMT_I: word_c = {in_imm[11:0], in_r1, in_f3, in_rd, in_opcode};
            FMT_S: word_c = {in_imm[11:5], in_r2, in_r1, in_f3,
                             in_imm[4:0], in_opcode};
            FMT_B: word_c = {in_imm[12], in_imm[10:5], in_r2, in_r1, in_f3,
                             in_imm[4:1], in_imm[11], in_opcode};
            FMT_U: word_c = {in_imm[31:12], in_rd, in_opcode};
            FMT_J: word_c = {in_imm[20], in_imm[10:1], in_imm[11],
                             in_imm[19:12], in_rd, in_opcode};
            default: fmt_ok_c = 1'b0;
        endcase
    end

`ifdef IMM_RANGE_CHECK_EN
    logic fit12_c;
    logic fit13_c;
    logic fit21_c;

    // A value fits in an N-bit signed field when bits [31:N-1] are all equal.
    always_comb begin
        fit12_c    = (&in_imm[31:11]) | ~(|in_imm[31:11]);
        fit13_c    = (&in_imm[31:12]) | ~(|in_imm[31:12]);
        fit21_c    = (&in_imm[31:20]) | ~(|in_imm[31:20]);
        range_ok_c = 1'b1;
        case (in_fmt)
            FMT_I, FMT_S: range_ok_c = fit12_c;
            FMT_B:        range_ok_c = fit13_c & ~in_imm[0];
            FMT_J:        range_ok_c = fit21_c & ~in_imm[0];
            FMT_U:        range_ok_c = ~(|in_imm[11:0]);
            default:      range_ok_c = 1'b1;
        endcase
    end

    // Range error only reported for otherwise legal formats.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_range <= 1'b0;
        end else begin
            err_range <= accept_c & fmt_ok_c & ~range_ok_c;
        end
    end
`else
    assign range_ok_c = 1'b1;
    assign err_range  = 1'b0;
`endif

    // Pointers, address counter, ready enable and format error pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            next_addr <= '0;
            rdy_q     <= 1'b0;
            err_fmt   <= 1'b0;
        end else begin
            rdy_q   <= 1'b1;
            err_fmt <= accept_c & ~fmt_ok_c;
            if (start) begin
                wr_ptr    <= '0;
                rd_ptr    <= '0;
                next_addr <= base_addr;
            end else begin
                if (push_c) begin
                    wr_ptr    <= wr_ptr + PTR_W'(1);
                    next_addr <= next_addr + ADDR_W'(4);
                end
                if (pop_c) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
            end
        end
    end

    // Storage array; contents are qualified by the pointers, so no reset.
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem[wr_ptr[IDX_W-1:0]] <= '{instr: word_c, addr: next_addr};
        end
    end

    // Head presentation; an empty FIFO shows zeros.
    always_comb begin
        out_valid = ~empty_c;
        out_instr = '0;
        out_addr  = '0;
        if (!empty_c) begin
            out_instr = mem[rd_ptr[IDX_W-1:0]].instr;
            out_addr  = mem[rd_ptr[IDX_W-1:0]].addr;
        end
    end

    assign count = wr_ptr - rd_ptr;

endmodule

// File: tb/tb_instruction_encoder_rv32i.sv
// Testbench for instruction_encoder_rv32i: fixed encoding table, directed
// corner sequences and randomized traffic against a queue-based model.
module tb_instruction_encoder_rv32i;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] base_addr;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_fmt;
    logic [6:0]  in_opcode;
    logic [4:0]  in_rd;
    logic [2:0]  in_f3;
    logic [4:0]  in_r1;
    logic [4:0]  in_r2;
    logic [6:0]  in_f7;
    logic [31:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_addr;
    logic [2:0]  count;
    logic        err_fmt;
    logic        err_range;

    always #5 clk = ~clk;

    instruction_encoder_rv32i #(.DEPTH(DEPTH), .ADDR_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .in_valid(in_valid), .in_ready(in_ready), .in_fmt(in_fmt),
        .in_opcode(in_opcode), .in_rd(in_rd), .in_f3(in_f3), .in_r1(in_r1),
        .in_r2(in_r2), .in_f7(in_f7), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_addr(out_addr), .count(count), .err_fmt(err_fmt),
        .err_range(err_range)
    );

    typedef struct {
        logic [2:0]  fmt;
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic [6:0]  f7;
        logic [31:0] imm;
    } bundle_t;

    typedef struct {
        bundle_t     b;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] addr;
    } exp_t;

    int          n_chk = 0;
    int          n_pass = 0;
    exp_t        q[$];
    logic [31:0] nxt = 32'h0;
    vec_t        tbl[7];

    function automatic bundle_t mk(input logic [2:0] fmt, input logic [6:0] op,
                                   input logic [4:0] rd, input logic [2:0] f3,
                                   input logic [4:0] r1, input logic [4:0] r2,
                                   input logic [6:0] f7, input logic [31:0] imm);
        bundle_t b;
        b.fmt = fmt; b.op = op; b.rd = rd; b.f3 = f3;
        b.r1 = r1; b.r2 = r2; b.f7 = f7; b.imm = imm;
        return b;
    endfunction

    // Reference encoding built from shifted/masked field values.
    function automatic logic [31:0] ref_enc(input bundle_t b);
        logic [31:0] op, rd, f3, r1, r2, f7, im;
        op = 32'(b.op); rd = 32'(b.rd); f3 = 32'(b.f3);
        r1 = 32'(b.r1); r2 = 32'(b.r2); f7 = 32'(b.f7); im = b.imm;
        case (b.fmt)
            3'd0: return op + (rd << 7) + (f3 << 12) + (r1 << 15) + (r2 << 20) + (f7 << 25);
            3'd1: return op + (rd << 7) + (f3 << 12) + (r1 << 15) + ((im & 32'hFFF) << 20);
            3'd2: return op + ((im & 32'h1F) << 7) + (f3 << 12) + (r1 << 15) + (r2 << 20)
                         + (((im >> 5) & 32'h7F) << 25);
            3'd3: return op + (((im >> 11) & 32'h1) << 7) + (((im >> 1) & 32'hF) << 8)
                         + (f3 << 12) + (r1 << 15) + (r2 << 20)
                         + (((im >> 5) & 32'h3F) << 25) + (((im >> 12) & 32'h1) << 31);
            3'd4: return op + (rd << 7) + (im & 32'hFFFFF000);
            3'd5: return op + (rd << 7) + (((im >> 12) & 32'hFF) << 12)
                         + (((im >> 11) & 32'h1) << 20) + (((im >> 1) & 32'h3FF) << 21)
                         + (((im >> 20) & 32'h1) << 31);
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic imm_legal(input bundle_t b);
`ifdef IMM_RANGE_CHECK_EN
        int v;
        logic even;
        v = int'(signed'(b.imm));
        even = ((b.imm & 32'h1) == 32'h0);
        case (b.fmt)
            3'd1, 3'd2: return (v >= -2048) && (v <= 2047);
            3'd3:       return (v >= -4096) && (v <= 4094) && even;
            3'd5:       return (v >= -1048576) && (v <= 1048574) && even;
            3'd4:       return (b.imm & 32'hFFF) == 32'h0;
            default:    return 1'b1;
        endcase
`else
        return (b.fmt <= 3'd5) || (b.fmt > 3'd5);
`endif
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    endtask

    // One clock cycle: drive, check in_ready, advance model, check outputs.
    // Called at posedge+1; returns at the following posedge+1.
    task automatic step(input logic v, input bundle_t b, input logic ordy,
                        input logic st, input logic [31:0] base);
        logic exp_rdy, exp_ef, exp_er;
        in_valid = v; in_fmt = b.fmt; in_opcode = b.op; in_rd = b.rd;
        in_f3 = b.f3; in_r1 = b.r1; in_r2 = b.r2; in_f7 = b.f7; in_imm = b.imm;
        out_ready = ordy; start = st; base_addr = base;
        #1;
        exp_rdy = !st && (q.size() < DEPTH);
        chk("in_ready", 64'(in_ready), 64'(exp_rdy));
        exp_ef = 1'b0;
        exp_er = 1'b0;
        if (st) begin
            q.delete();
            nxt = base;
        end else begin
            if (q.size() > 0 && ordy) void'(q.pop_front());
            if (v && exp_rdy) begin
                if (b.fmt > 3'd5) exp_ef = 1'b1;
                else if (!imm_legal(b)) exp_er = 1'b1;
                else begin
                    q.push_back('{ref_enc(b), nxt});
                    nxt = nxt + 32'd4;
                end
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0; start = 1'b0; out_ready = 1'b0;
        chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
        chk("count", 64'(count), 64'(q.size()));
        chk("err_fmt", 64'(err_fmt), 64'(exp_ef));
        chk("err_range", 64'(err_range), 64'(exp_er));
        if (q.size() > 0) begin
            chk("out_instr", 64'(out_instr), 64'(q[0].instr));
            chk("out_addr", 64'(out_addr), 64'(q[0].addr));
        end
    endtask

    task automatic idle(input logic ordy);
        step(1'b0, mk(3'd0, 7'h0, 5'd0, 3'd0, 5'd0, 5'd0, 7'h0, 32'h0), ordy, 1'b0, 32'h0);
    endtask

    task automatic do_start(input logic [31:0] base);
        step(1'b0, mk(3'd0, 7'h0, 5'd0, 3'd0, 5'd0, 5'd0, 7'h0, 32'h0), 1'b0, 1'b1, base);
    endtask

    function automatic bundle_t rnd_bundle();
        logic [2:0]  f;
        logic [31:0] im;
        f = ($urandom % 8 == 0) ? 3'(6 + ($urandom % 2)) : 3'($urandom % 6);
        im = ($urandom % 4 == 0) ? $urandom : 32'($urandom_range(0, 8191)) - 32'd4096;
        return mk(f, 7'($urandom), 5'($urandom), 3'($urandom), 5'($urandom),
                  5'($urandom), 7'($urandom), im);
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bundle_t addi4;
        tbl[0] = '{mk(3'd0, 7'h33, 5'd1, 3'd0, 5'd2, 5'd3, 7'h00, 32'd0),   32'h003100B3};
        tbl[1] = '{mk(3'd1, 7'h13, 5'd1, 3'd0, 5'd2, 5'd31, 7'h7F, 32'd20), 32'h01410093};
        tbl[2] = '{mk(3'd3, 7'h63, 5'd9, 3'd0, 5'd1, 5'd2, 7'h00, 32'hFFFFFFFC), 32'hFE208EE3};
        tbl[3] = '{mk(3'd2, 7'h23, 5'd0, 3'd2, 5'd1, 5'd2, 7'h00, 32'd8),   32'h0020A423};
        tbl[4] = '{mk(3'd4, 7'h37, 5'd5, 3'd0, 5'd0, 5'd0, 7'h00, 32'h12345000), 32'h123452B7};
        tbl[5] = '{mk(3'd5, 7'h6F, 5'd1, 3'd0, 5'd0, 5'd0, 7'h00, 32'h800), 32'h001000EF};
        tbl[6] = '{mk(3'd1, 7'h13, 5'd1, 3'd0, 5'd2, 5'd0, 7'h00, 32'd4096), 32'h00010093};

        rst_n = 1'b0; start = 1'b0; base_addr = 32'h0; in_valid = 1'b0;
        out_ready = 1'b0; in_fmt = 3'd0; in_opcode = 7'h0; in_rd = 5'd0;
        in_f3 = 3'd0; in_r1 = 5'd0; in_r2 = 5'd0; in_f7 = 7'h0; in_imm = 32'h0;

        // Reset values
        #2;
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_out_instr", 64'(out_instr), 64'd0);
        chk("rst_out_addr", 64'(out_addr), 64'd0);
        chk("rst_err_fmt", 64'(err_fmt), 64'd0);
        chk("rst_err_range", 64'(err_range), 64'd0);
        #10;
        rst_n = 1'b1;
        #1;
        chk("rel_in_ready_low", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        chk("rel_in_ready_high", 64'(in_ready), 64'd1);

        // Encoding table, one word at a time from base 0x100
        do_start(32'h100);
        for (int i = 0; i < 7; i++) begin
            step(1'b1, tbl[i].b, 1'b0, 1'b0, 32'h0);
            if (q.size() == 1) begin
                chk($sformatf("tbl_instr_%0d", i), 64'(out_instr), 64'(tbl[i].exp));
                chk($sformatf("tbl_addr_%0d", i), 64'(out_addr), 64'(32'h100 + 32'(4 * i)));
            end
            idle(1'b1);
        end

        // Back-to-back into a full FIFO, single pop frees one slot
        do_start(32'h40);
        for (int i = 0; i < 5; i++)
            step(1'b1, mk(3'd1, 7'h13, 5'(i + 1), 3'd0, 5'd2, 5'd0, 7'h0, 32'(i)), 1'b0, 1'b0, 32'h0);
        chk("full_count", 64'(count), 64'd4);
        chk("full_in_ready", 64'(in_ready), 64'd0);
        step(1'b1, mk(3'd1, 7'h13, 5'd5, 3'd0, 5'd2, 5'd0, 7'h0, 32'd4), 1'b1, 1'b0, 32'h0);
        step(1'b1, mk(3'd1, 7'h13, 5'd5, 3'd0, 5'd2, 5'd0, 7'h0, 32'd4), 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 5; i++) idle(1'b1);

        // Illegal format is consumed without advancing the address
        step(1'b1, mk(3'd7, 7'h13, 5'd1, 3'd0, 5'd2, 5'd0, 7'h0, 32'd1), 1'b0, 1'b0, 32'h0);
        step(1'b1, mk(3'd6, 7'h33, 5'd1, 3'd0, 5'd2, 5'd3, 7'h0, 32'd0), 1'b0, 1'b0, 32'h0);
        step(1'b1, tbl[0].b, 1'b0, 1'b0, 32'h0);
        idle(1'b1);

        // Address wrap
        do_start(32'hFFFFFFFC);
        step(1'b1, tbl[0].b, 1'b0, 1'b0, 32'h0);
        step(1'b1, tbl[1].b, 1'b0, 1'b0, 32'h0);
        chk("wrap_addr0", 64'(out_addr), 64'(32'hFFFFFFFC));
        idle(1'b1);
        chk("wrap_addr1", 64'(out_addr), 64'd0);
        idle(1'b1);

        // Start flushes the FIFO and blocks a concurrent bundle
        for (int i = 0; i < 3; i++) step(1'b1, tbl[3].b, 1'b0, 1'b0, 32'h0);
        step(1'b1, tbl[4].b, 1'b1, 1'b1, 32'h200);
        chk("flush_count", 64'(count), 64'd0);
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        step(1'b1, tbl[5].b, 1'b0, 1'b0, 32'h0);
        chk("flush_addr", 64'(out_addr), 64'(32'h200));
        idle(1'b1);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            if ($urandom % 60 == 0)
                step(1'($urandom), rnd_bundle(), 1'($urandom), 1'b1, $urandom & 32'hFFFFFFFC);
            else
                step(1'($urandom % 3 != 0), rnd_bundle(), 1'($urandom % 2), 1'b0, 32'h0);
        end

        // Asynchronous reset in the middle of a stream
        step(1'b1, tbl[0].b, 1'b0, 1'b0, 32'h0);
        step(1'b1, tbl[1].b, 1'b0, 1'b0, 32'h0);
        addi4 = tbl[1].b;
        in_valid = 1'b1; in_fmt = addi4.fmt; in_imm = addi4.imm;
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_count", 64'(count), 64'd0);
        chk("mid_rst_out_instr", 64'(out_instr), 64'd0);
        chk("mid_rst_out_addr", 64'(out_addr), 64'd0);
        chk("mid_rst_in_ready", 64'(in_ready), 64'd0);
        chk("mid_rst_err_fmt", 64'(err_fmt), 64'd0);
        in_valid = 1'b0;
        #3;
        rst_n = 1'b1;
        q.delete();
        nxt = 32'h0;
        @(posedge clk);
        #1;
        step(1'b1, tbl[2].b, 1'b0, 1'b0, 32'h0);
        chk("post_rst_addr", 64'(out_addr), 64'd0);
        idle(1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
